ddr3_app_arbiter: RTL and testbench
===================================

Name: ddr3_app_arbiter

Overview:
- Two-client round-robin arbiter/sequencer in front of the DDR3 controller's 256-bit application interface.
- Waits for calibration, then serializes client read/write commands onto app_cmd/app_en and the write-data channel.
- Holds each command through app_rdy/app_wdf_rdy backpressure.
- Routes returning read data to the issuing client via an in-order tag FIFO.

Parameters:
ADDR_W, 28, app address width
DATA_W, 256, data width (one burst beat per command)
MASK_W, 32, byte mask width (DATA_W/8)
TAG_DEPTH, 32, max outstanding reads (power of 2)

Ports:
CLK  in  1  single clock (controller UI clock)
RST_N  in  1  asynchronous active-low reset
calib_done  in  1  controller init_calib_complete
cN_req_valid  in  1  client N (N=0,1) command valid
cN_req_ready  out  1  client N command accepted this cycle
cN_req_write  in  1  1=write, 0=read
cN_req_addr  in  ADDR_W  command address
cN_req_wdata  in  DATA_W  write data
cN_req_mask  in  MASK_W  byte mask, 1=byte not written
cN_rsp_valid  out  1  read data valid for client N (no backpressure)
cN_rsp_data  out  DATA_W  read data
app_addr  out  ADDR_W  to controller
app_cmd  out  3  3'b000 write, 3'b001 read
app_en  out  1  command strobe
app_rdy  in  1  controller command ready
app_wdf_data  out  DATA_W  write data
app_wdf_mask  out  MASK_W  write mask
app_wdf_wren  out  1  write data strobe
app_wdf_end  out  1  equals app_wdf_wren (single-beat bursts)
app_wdf_rdy  in  1  write FIFO ready
app_rd_data  in  DATA_W  read data
app_rd_data_valid  in  1  read data strobe
tag_err  out  1  sticky: read data arrived with tag FIFO empty

Behaviour:
- Reset (async assert, deassert sampled on CLK): all outputs 0, state WAIT_CAL, RR pointer favours client 0, tag FIFO empty, tag_err 0.
- FSM WAIT_CAL: no grants; go to IDLE when calib_done=1.
- FSM IDLE: choose requester. A read is eligible only if the tag FIFO is not full.
  - Both eligible: grant non-pointer client's opposite, i.e. the pointer client, then flip pointer to the other.
  - One eligible: grant it; pointer points to the other.
  - Grant: cN_req_ready=1 for exactly that cycle; latch addr/write/wdata/mask; go ISSUE.
  - calib_done=0 in IDLE -> WAIT_CAL.
- FSM ISSUE, entered cycle N+1 after grant at N:
  - app_en=1, app_addr/app_cmd held stable until app_en&app_rdy.
  - If write, app_wdf_wren=app_wdf_end=1 with data/mask held until app_wdf_wren&app_wdf_rdy.
  - cmd_done and wdf_done flags are tracked independently; each strobe drops the cycle after its own acceptance.
  - Both done (wdf_done forced 1 for reads) -> IDLE. Minimum 1 ISSUE cycle; throughput 1 command per 2 cycles.
- Tag FIFO:
  - Push granted client ID on read app_en&app_rdy.
  - Pop on app_rd_data_valid; same-cycle push and pop allowed, including when full or empty-with-push.
  - Read data is registered: cN_rsp_valid/cN_rsp_data asserted 1 cycle after app_rd_data_valid, for FIFO head client only; other client's rsp_valid stays 0.
  - app_rd_data_valid with FIFO empty and no same-cycle push: set tag_err, drop data.
- calib_done falling during ISSUE: finish command, then go to WAIT_CAL. Outstanding reads still drain and route.
- cN_req_* must be held stable while cN_req_valid=1 and not granted. A client may withdraw the request only if not granted.

Optional Feature:
- DDR3_ARB_STATS_EN defined: adds per-client 32-bit wrapping counters (c0_cmd_cnt, c1_cmd_cnt) incremented on command acceptance (app_en&app_rdy).
- Also adds a 32-bit stall_cnt incremented each ISSUE cycle where a pending strobe is not accepted.
- All counters reset to 0 by RST_N.
- Not defined: counter ports still present, tied to 0, no counter logic.

Test Plan:
- calib_done=0, c0 read valid 20 cycles -> no c0_req_ready, app_en=0. Raise calib_done -> grant within 2 cycles, app_en next cycle.
- Both clients stream reads, app_rdy=1 -> grants alternate c0,c1,c0,c1. Data returned in order 0xA..,0xB.. routes to c0 then c1.
- c1 write addr 0x100, app_rdy=0 for 5 cycles, app_wdf_rdy=1 immediately -> wren lasts 1 cycle, app_en held 6 cycles with stable addr, then IDLE.
- 32 c0 reads accepted, no returns -> next read not granted; a c1 write is still granted. One app_rd_data_valid -> read grant resumes.
- app_rd_data_valid with empty FIFO -> tag_err=1 and stays 1. RST_N low mid-ISSUE -> app_en/app_wdf_wren=0 immediately, tag_err clears.
- With DDR3_ARB_STATS_EN: 3 c0 cmds, 2 c1 cmds, app_rdy low 4 cycles -> c0_cmd_cnt=3, c1_cmd_cnt=2, stall_cnt=4.

Source files
------------

// File: rtl/ddr3_app_arbiter_if.sv
// ddr3_app_arbiter_if: DDR3 controller application-side command, write-data
// and read-data signals. The arbiter uses the master modport. The controller,
// or a bench standing in for it, uses the slave modport.
interface ddr3_app_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32
);
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// ddr3_app_arbiter: two-client round-robin sequencer in front of a DDR3
// controller's application interface. The block waits for calibration and
// then issues one command per grant. Read data comes back in order, and an
// in-order tag FIFO steers each returning beat to the client that issued it.
// Optional build macro DDR3_ARB_STATS_EN adds per-client command counters and
// a stall counter. Without the macro, those ports read 0.
//
// Handshake rules:
// - Client side: a command transfers in the cycle where cN_req_valid and
//   cN_req_ready are both 1. A client holds its request stable until that
//   cycle, and may drop valid only while it has not been granted.
// - Controller side: app_en and app_wdf_wren each stay high, with their
//   payload held, until the cycle where app_rdy or app_wdf_rdy is also high.
// - The response side has no backpressure.
module ddr3_app_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 256,
  parameter int MASK_W    = 32,
  parameter int TAG_DEPTH = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              calib_done,
  input  logic              c0_req_valid,
  output logic              c0_req_ready,
  input  logic              c0_req_write,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [DATA_W-1:0] c0_req_wdata,
  input  logic [MASK_W-1:0] c0_req_mask,
  output logic              c0_rsp_valid,
  output logic [DATA_W-1:0] c0_rsp_data,
  input  logic              c1_req_valid,
  output logic              c1_req_ready,
  input  logic              c1_req_write,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [DATA_W-1:0] c1_req_wdata,
  input  logic [MASK_W-1:0] c1_req_mask,
  output logic              c1_rsp_valid,
  output logic [DATA_W-1:0] c1_rsp_data,
  ddr3_app_arbiter_if.master app,
  output logic              tag_err,
  output logic [31:0]       c0_cmd_cnt,
  output logic [31:0]       c1_cmd_cnt,
  output logic [31:0]       stall_cnt,
  output logic [1:0]        state_dbg_o
);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {WAIT_CAL = 2'd0, IDLE = 2'd1, ISSUE = 2'd2} state_t;

  state_t            state_q;
  logic              rr_q;       // client favoured when both are eligible
  logic              gnt_id_q;   // client owning the command in flight
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        cmd_q;
  logic              en_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;
  logic              wren_q;

  logic              tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  tag_cnt_q, tag_cnt_d;
  logic              rsp0_q, rsp1_q, tag_err_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic tag_full, tag_empty, elig0, elig1, can_grant, gnt_sel;
  logic cmd_acc, wdf_acc, cmd_fin, wdf_fin, tag_push, tag_pop, head_id;

  // Grant selection. A read is eligible only while its tag can be stored.
  always_comb begin
    tag_full  = (tag_cnt_q == CNT_W'(TAG_DEPTH));
    tag_empty = (tag_cnt_q == '0);
    elig0     = c0_req_valid & (c0_req_write | ~tag_full);
    elig1     = c1_req_valid & (c1_req_write | ~tag_full);
    can_grant = (state_q == IDLE) & calib_done & (elig0 | elig1);
    gnt_sel   = (elig0 & elig1) ? rr_q : elig1;
    c0_req_ready = can_grant & ~gnt_sel;
    c1_req_ready = can_grant &  gnt_sel;
  end

  // Controller acceptance and tag FIFO bookkeeping. An empty FIFO with a
  // push in the same cycle forwards the pushed ID straight to the head.
  always_comb begin
    cmd_acc   = en_q & app.app_rdy;
    wdf_acc   = wren_q & app.app_wdf_rdy;
    cmd_fin   = ~en_q | app.app_rdy;
    wdf_fin   = ~wren_q | app.app_wdf_rdy;
    tag_push  = cmd_acc & (cmd_q == CMD_RD);
    tag_pop   = app.app_rd_data_valid & (~tag_empty | tag_push);
    head_id   = tag_empty ? gnt_id_q : tag_mem_q[rd_ptr_q];
    tag_cnt_d = tag_cnt_q + CNT_W'(tag_push) - CNT_W'(tag_pop);
  end

  // Sequencing FSM and the registered command and write-data strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= WAIT_CAL;
      rr_q     <= 1'b0;
      gnt_id_q <= 1'b0;
      addr_q   <= '0;
      cmd_q    <= '0;
      en_q     <= 1'b0;
      wdata_q  <= '0;
      mask_q   <= '0;
      wren_q   <= 1'b0;
    end else begin
      case (state_q)
        WAIT_CAL: if (calib_done) state_q <= IDLE;
        IDLE: begin
          if (!calib_done) begin
            state_q <= WAIT_CAL;
          end else if (can_grant) begin
            gnt_id_q <= gnt_sel;
            rr_q     <= ~gnt_sel;
            addr_q   <= gnt_sel ? c1_req_addr : c0_req_addr;
            cmd_q    <= (gnt_sel ? c1_req_write : c0_req_write) ? CMD_WR : CMD_RD;
            wdata_q  <= gnt_sel ? c1_req_wdata : c0_req_wdata;
            mask_q   <= gnt_sel ? c1_req_mask : c0_req_mask;
            wren_q   <= gnt_sel ? c1_req_write : c0_req_write;
            en_q     <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_acc) en_q <= 1'b0;
          if (wdf_acc) wren_q <= 1'b0;
          if (cmd_fin && wdf_fin) state_q <= calib_done ? IDLE : WAIT_CAL;
        end
        default: state_q <= WAIT_CAL;
      endcase
    end
  end

  // Tag FIFO pointers and occupancy, plus registered read-data routing.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_cnt_q  <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rsp_data_q <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      if (tag_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (tag_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      tag_cnt_q <= tag_cnt_d;
      rsp0_q    <= tag_pop & ~head_id;
      rsp1_q    <= tag_pop &  head_id;
      if (tag_pop) rsp_data_q <= app.app_rd_data;
      if (app.app_rd_data_valid && tag_empty && !tag_push) tag_err_q <= 1'b1;
    end
  end

  // Tag storage. Entries are only read after they have been written.
  always_ff @(posedge CLK) begin
    if (tag_push) tag_mem_q[wr_ptr_q] <= gnt_id_q;
  end

`ifdef DDR3_ARB_STATS_EN
  logic [31:0] c0_cnt_q, c1_cnt_q, stall_q;
  // Command acceptance counters per client, and stall cycles in ISSUE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c0_cnt_q <= '0;
      c1_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      if (cmd_acc && !gnt_id_q) c0_cnt_q <= c0_cnt_q + 32'd1;
      if (cmd_acc &&  gnt_id_q) c1_cnt_q <= c1_cnt_q + 32'd1;
      if ((state_q == ISSUE) &&
          ((en_q && !app.app_rdy) || (wren_q && !app.app_wdf_rdy)))
        stall_q <= stall_q + 32'd1;
    end
  end
  assign c0_cmd_cnt = c0_cnt_q;
  assign c1_cmd_cnt = c1_cnt_q;
  assign stall_cnt  = stall_q;
`else
  assign c0_cmd_cnt = 32'd0;
  assign c1_cmd_cnt = 32'd0;
  assign stall_cnt  = 32'd0;
`endif

  assign app.app_addr     = addr_q;
  assign app.app_cmd      = cmd_q;
  assign app.app_en       = en_q;
  assign app.app_wdf_data = wdata_q;
  assign app.app_wdf_mask = mask_q;
  assign app.app_wdf_wren = wren_q;
  assign app.app_wdf_end  = wren_q;
  assign c0_rsp_valid     = rsp0_q;
  assign c1_rsp_valid     = rsp1_q;
  assign c0_rsp_data      = rsp_data_q;
  assign c1_rsp_data      = rsp_data_q;
  assign tag_err          = tag_err_q;
  assign state_dbg_o      = state_q;
endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// tb_ddr3_app_arbiter: directed bench for ddr3_app_arbiter. Every expected
// value is computed by hand from the intended cycle-by-cycle behaviour.
module tb_ddr3_app_arbiter;
  logic         CLK = 1'b0;
  logic         RST_N;
  logic         calib_done;
  logic         c0_req_valid, c0_req_ready, c0_req_write, c0_rsp_valid;
  logic [27:0]  c0_req_addr;
  logic [255:0] c0_req_wdata, c0_rsp_data;
  logic [31:0]  c0_req_mask;
  logic         c1_req_valid, c1_req_ready, c1_req_write, c1_rsp_valid;
  logic [27:0]  c1_req_addr;
  logic [255:0] c1_req_wdata, c1_rsp_data;
  logic [31:0]  c1_req_mask;
  logic         tag_err;
  logic [31:0]  c0_cmd_cnt, c1_cmd_cnt, stall_cnt;
  logic [1:0]   state_dbg_o;

  int checks = 0;
  int errors = 0;

`ifdef DDR3_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  ddr3_app_arbiter_if #(.ADDR_W(28), .DATA_W(256), .MASK_W(32)) app_if ();

  ddr3_app_arbiter dut (
    .CLK(CLK), .RST_N(RST_N), .calib_done(calib_done),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready),
    .c0_req_write(c0_req_write), .c0_req_addr(c0_req_addr),
    .c0_req_wdata(c0_req_wdata), .c0_req_mask(c0_req_mask),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready),
    .c1_req_write(c1_req_write), .c1_req_addr(c1_req_addr),
    .c1_req_wdata(c1_req_wdata), .c1_req_mask(c1_req_mask),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_data(c1_rsp_data),
    .app(app_if), .tag_err(tag_err),
    .c0_cmd_cnt(c0_cmd_cnt), .c1_cmd_cnt(c1_cmd_cnt), .stall_cnt(stall_cnt),
    .state_dbg_o(state_dbg_o)
  );

  // Clock and reset.
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut(input bit cal);
    RST_N = 1'b0;
    calib_done = 1'b0;
    c0_req_valid = 0; c0_req_write = 0; c0_req_addr = '0; c0_req_wdata = '0; c0_req_mask = '0;
    c1_req_valid = 0; c1_req_write = 0; c1_req_addr = '0; c1_req_wdata = '0; c1_req_mask = '0;
    app_if.app_rdy = 1'b1;
    app_if.app_wdf_rdy = 1'b1;
    app_if.app_rd_data = '0;
    app_if.app_rd_data_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc();
    if (cal) begin
      calib_done = 1'b1;
      cyc();
    end
  endtask

  // Driver: one write from a client, with the controller refusing the
  // command for rdy_low ISSUE cycles. The task returns in IDLE, just after
  // a clock edge.
  task automatic issue_wr(input bit cl, input logic [27:0] a, input int rdy_low);
    if (cl) begin
      c1_req_valid = 1; c1_req_write = 1; c1_req_addr = a;
    end else begin
      c0_req_valid = 1; c0_req_write = 1; c0_req_addr = a;
    end
    @(negedge CLK);
    chk("iss_ready", cl ? c1_req_ready : c0_req_ready, 1'b1);
    cyc();
    c0_req_valid = 0;
    c1_req_valid = 0;
    app_if.app_rdy = (rdy_low == 0);
    repeat (rdy_low) cyc();
    app_if.app_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (state_dbg_o == 2'd1) break;
      cyc();
    end
    chk("iss_done", state_dbg_o, 2'd1);
    cyc();
  endtask

  initial begin
    int bad, en_cnt, wren_cnt, grants;
    logic [255:0] ret_d [4];
    ret_d[0] = 256'hA0; ret_d[1] = 256'hB0; ret_d[2] = 256'hA1; ret_d[3] = 256'hB1;

    // ---- Reset state, then hold a read while calibration is pending.
    RST_N = 1'b0;
    reset_dut(1'b0);
    chk("rst_en", app_if.app_en, 1'b0);
    chk("rst_wren", app_if.app_wdf_wren, 1'b0);
    chk("rst_tag_err", tag_err, 1'b0);
    chk("rst_state", state_dbg_o, 2'd0);
    chk("rst_rsp", {c0_rsp_valid, c1_rsp_valid}, 2'b00);
    c0_req_valid = 1; c0_req_write = 0; c0_req_addr = 28'h10;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      bad += int'(c0_req_ready) + int'(app_if.app_en);
      cyc();
    end
    chk("cal_nogrant", bad, 0);
    chk("cal_state", state_dbg_o, 2'd0);
    calib_done = 1;
    @(negedge CLK);
    chk("cal_gnt_t0", c0_req_ready, 1'b0);
    cyc();
    @(negedge CLK);
    chk("cal_gnt_t1", c0_req_ready, 1'b1);
    cyc();
    c0_req_valid = 0;
    @(negedge CLK);
    chk("cal_en", app_if.app_en, 1'b1);
    chk("cal_cmd", app_if.app_cmd, 3'b001);
    chk("cal_addr", app_if.app_addr, 28'h10);
    cyc();
    app_if.app_rd_data_valid = 1; app_if.app_rd_data = 256'h11;
    @(negedge CLK);
    chk("cal_en_drop", app_if.app_en, 1'b0);
    cyc();
    app_if.app_rd_data_valid = 0;
    @(negedge CLK);
    chk("cal_rsp_v", {c0_rsp_valid, c1_rsp_valid}, 2'b10);
    chk("cal_rsp_d", c0_rsp_data, 256'h11);
    cyc();
    @(negedge CLK);
    chk("cal_rsp_pulse", c0_rsp_valid, 1'b0);

    // ---- Round robin with both clients streaming reads.
    reset_dut(1'b1);
    c0_req_valid = 1; c0_req_write = 0; c0_req_addr = 28'h200;
    c1_req_valid = 1; c1_req_write = 0; c1_req_addr = 28'h300;
    for (int g = 0; g < 4; g++) begin
      @(negedge CLK);
      chk("rr_gnt0", c0_req_ready, (g % 2 == 0));
      chk("rr_gnt1", c1_req_ready, (g % 2 == 1));
      cyc();
      if (g % 2 == 0) c0_req_addr = c0_req_addr + 1;
      else            c1_req_addr = c1_req_addr + 1;
      if (g == 2) c0_req_valid = 0;
      if (g == 3) c1_req_valid = 0;
      @(negedge CLK);
      chk("rr_addr", app_if.app_addr, (g % 2 == 0) ? 28'h200 + 28'(g / 2) : 28'h300 + 28'(g / 2));
      chk("rr_issue_nogrant", {c0_req_ready, c1_req_ready}, 2'b00);
      cyc();
    end
    app_if.app_rd_data_valid = 1; app_if.app_rd_data = ret_d[0];
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k < 3) app_if.app_rd_data = ret_d[k + 1];
      else       app_if.app_rd_data_valid = 0;
      @(negedge CLK);
      chk("ret_route", {c0_rsp_valid, c1_rsp_valid}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("ret_data", (k % 2 == 0) ? c0_rsp_data : c1_rsp_data, ret_d[k]);
    end
    chk("ret_tag_err", tag_err, 1'b0);

    // ---- Write held through app_rdy backpressure.
    reset_dut(1'b1);
    app_if.app_rdy = 0;
    c1_req_valid = 1; c1_req_write = 1; c1_req_addr = 28'h100;
    c1_req_wdata = 256'hDEAD_BEEF; c1_req_mask = 32'h0000_000F;
    @(negedge CLK);
    chk("wr_gnt", {c0_req_ready, c1_req_ready}, 2'b01);
    en_cnt = 0; wren_cnt = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      c1_req_valid = 0;
      app_if.app_rdy = (i >= 5);
      @(negedge CLK);
      en_cnt += int'(app_if.app_en);
      wren_cnt += int'(app_if.app_wdf_wren);
      if (app_if.app_en && (app_if.app_addr != 28'h100 || app_if.app_cmd != 3'b000)) bad++;
      if (i == 0) begin
        chk("wr_end", app_if.app_wdf_end, 1'b1);
        chk("wr_data", app_if.app_wdf_data, 256'hDEAD_BEEF);
        chk("wr_mask", app_if.app_wdf_mask, 32'h0000_000F);
      end
    end
    chk("wr_en_cycles", en_cnt, 6);
    chk("wr_wren_cycles", wren_cnt, 1);
    chk("wr_addr_stable", bad, 0);
    chk("wr_idle", state_dbg_o, 2'd1);

    // ---- Tag FIFO full blocks reads but not writes.
    reset_dut(1'b1);
    c0_req_valid = 1; c0_req_write = 0; c0_req_addr = 28'h40;
    grants = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      grants += int'(c0_req_ready);
      cyc();
    end
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge CLK);
      bad += int'(c0_req_ready) + int'(app_if.app_en);
      cyc();
    end
    chk("full_grants", grants, 32);
    chk("full_blocked", bad, 0);
    c1_req_valid = 1; c1_req_write = 1; c1_req_addr = 28'h140;
    @(negedge CLK);
    chk("full_wr_gnt", {c0_req_ready, c1_req_ready}, 2'b01);
    cyc();
    c1_req_valid = 0;
    @(negedge CLK);
    chk("full_wr_cmd", {app_if.app_en, app_if.app_wdf_wren, app_if.app_cmd}, 5'b11_000);
    cyc();
    @(negedge CLK);
    chk("full_still_blocked", c0_req_ready, 1'b0);
    cyc();
    app_if.app_rd_data_valid = 1; app_if.app_rd_data = 256'h55;
    @(negedge CLK);
    chk("full_pop_cycle", c0_req_ready, 1'b0);
    cyc();
    app_if.app_rd_data_valid = 0;
    @(negedge CLK);
    chk("full_resume", c0_req_ready, 1'b1);
    chk("full_rsp", {c0_rsp_valid, c1_rsp_valid, c0_rsp_data[7:0]}, {2'b10, 8'h55});
    cyc();
    c0_req_valid = 0;

    // ---- Stray read data, then asynchronous reset during ISSUE.
    reset_dut(1'b1);
    app_if.app_rd_data_valid = 1; app_if.app_rd_data = 256'h77;
    cyc();
    app_if.app_rd_data_valid = 0;
    @(negedge CLK);
    chk("err_set", tag_err, 1'b1);
    chk("err_drop", {c0_rsp_valid, c1_rsp_valid}, 2'b00);
    repeat (3) cyc();
    @(negedge CLK);
    chk("err_sticky", tag_err, 1'b1);
    cyc();
    app_if.app_rdy = 0; app_if.app_wdf_rdy = 0;
    c0_req_valid = 1; c0_req_write = 1; c0_req_addr = 28'h80;
    cyc();
    c0_req_valid = 0;
    @(negedge CLK);
    chk("arst_pre", {app_if.app_en, app_if.app_wdf_wren}, 2'b11);
    #1;
    RST_N = 0;
    #1;
    chk("arst_strobes", {app_if.app_en, app_if.app_wdf_wren}, 2'b00);
    chk("arst_tag_err", tag_err, 1'b0);
    chk("arst_state", state_dbg_o, 2'd0);

    // ---- Statistics counters (zero when the feature is not built).
    reset_dut(1'b1);
    issue_wr(1'b0, 28'h400, 4);
    issue_wr(1'b1, 28'h500, 0);
    issue_wr(1'b0, 28'h401, 0);
    issue_wr(1'b1, 28'h501, 0);
    issue_wr(1'b0, 28'h402, 0);
    @(negedge CLK);
    chk("stat_c0", c0_cmd_cnt, STATS ? 32'd3 : 32'd0);
    chk("stat_c1", c1_cmd_cnt, STATS ? 32'd2 : 32'd0);
    chk("stat_stall", stall_cnt, STATS ? 32'd4 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
